mips_control_unit: RTL and testbench
====================================

Name: mips_control_unit

Overview:
- Multicycle Moore control FSM for the MIPS datapath.
- Consumes the instruction fields (opcode, funct) and the ALU status flags from the datapath.
- Drives every mux select and register/memory write enable the datapath receives.
- Covers fetch/decode, R-type add/sub/and, addi, lw, sw, beq, bne, j, the stack-pointer init, and the invalid-opcode and overflow exception entry.

Parameters:
MEM_WAIT, 1, cycles between presenting a memory address and the read data being valid (>=1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
opcode  in  6  instruction register bits [31:26]
funct  in  6  instruction register bits [5:0]
zero  in  1  ALU result == 0
overflow  in  1  ALU signed overflow
pcWrite  out  1  PC load enable
iord  out  2  memory address select: 0=PC, 1=ALUOut, 2=exception vector address, 3=ALU result
excpControl  out  2  vector address select: 0=253 (opcode), 1=254 (overflow), 2=255 (reserved)
memWrite  out  1  memory write strobe
irWrite  out  1  instruction register load
abWrite  out  1  A/B register load
srcWrite  out  3  destination register select: 0=rt, 1=rd, 2=$29, 3=$30, 4=$31
srcData  out  4  register write data select: 0=ALUOut, 1=load data, 2=constant 227
regWrite  out  1  register file write enable
aluSrcA  out  2  ALU A operand: 0=PC, 1=A
aluSrcB  out  2  ALU B operand: 0=B, 1=4, 2=sign-extended immediate, 3=sign-extended immediate<<2
aluControl  out  3  ALU op: 001=add, 010=sub, 011=and; 000 when the ALU is idle
aluOutControl  out  1  ALUOut load enable
pcSource  out  3  PC input select: 0=ALU result, 1=ALUOut, 2=jump concat, 3=memory data register, 4=EPC
epcControl  out  1  EPC load enable

Behaviour:
General:
- Moore machine: outputs decode from state, plus the wait counter only where stated.
- Any output not listed for a state is 0.
- The datapath's memory data register loads every cycle.

Reset:
- reset=1 forces state RST and the wait counter to 0 immediately, asynchronously, from any state, including mid memory write.
- While reset is held, all outputs are 0.

RST (first cycle after release):
- regWrite=1, srcWrite=2, srcData=2 ($29 <= 227). Next: FETCH.

FETCH (lasts MEM_WAIT+1 cycles; wait counter counts 0..MEM_WAIT):
- Every cycle: iord=0, aluSrcA=0, aluSrcB=1, aluControl=add.
- Last cycle only: irWrite=1, pcWrite=1, pcSource=0 (PC <= PC+4). Next: DECODE.

DECODE:
- abWrite=1, aluSrcA=0, aluSrcB=3, aluControl=add, aluOutControl=1 (branch target).
- Dispatch:
  - opcode 0x00 with funct 0x20/0x22/0x24 -> R_EXEC; any other funct -> EXC_OPC.
  - 0x08 -> I_EXEC.
  - 0x23 or 0x2B -> ADDR.
  - 0x04 or 0x05 -> BRANCH.
  - 0x02 -> JUMP.
  - Anything else -> EXC_OPC.

R_EXEC:
- aluSrcA=1, aluSrcB=0, aluControl from funct (add/sub/and), aluOutControl=1.
- overflow=1 with add or sub -> EXC_OVF. overflow is ignored for and. Otherwise -> R_WB.

R_WB:
- regWrite=1, srcWrite=1, srcData=0. Next: FETCH.

I_EXEC:
- aluSrcA=1, aluSrcB=2, aluControl=add, aluOutControl=1.
- overflow=1 -> EXC_OVF; otherwise -> I_WB.

I_WB:
- regWrite=1, srcWrite=0, srcData=0. Next: FETCH.

ADDR:
- aluSrcA=1, aluSrcB=2, aluControl=add, aluOutControl=1.
- Next: LW_MEM for opcode 0x23, SW_MEM for 0x2B.

LW_MEM (MEM_WAIT cycles):
- iord=1. Next: LW_WB.

LW_WB:
- regWrite=1, srcWrite=0, srcData=1. Next: FETCH.

SW_MEM (exactly 1 cycle):
- iord=1, memWrite=1. Next: FETCH.

BRANCH:
- aluSrcA=1, aluSrcB=0, aluControl=sub.
- If (zero XOR opcode[0]) is 1: pcWrite=1, pcSource=1. Next: FETCH.

JUMP:
- pcWrite=1, pcSource=2. Next: FETCH.

EXC_OPC / EXC_OVF (lasts MEM_WAIT cycles):
- Every cycle: iord=2; excpControl=0 (EXC_OPC) or 1 (EXC_OVF).
- First cycle only: aluSrcA=0, aluSrcB=1, aluControl=sub, epcControl=1 (EPC <= PC-4).
- Next: EXC_LOAD.

EXC_LOAD:
- pcWrite=1, pcSource=3 (PC <= vector byte). Next: FETCH.

Wait counter:
- Clears on every state entry. Never exceeds MEM_WAIT.

Latencies with MEM_WAIT=1:
- R-type and addi: 5 cycles. lw: 6. sw: 5. beq/bne/j: 4. Exception entry to FETCH: 2 cycles.

Test Plan:
1. MEM_WAIT=1. Assert reset for 3 cycles, release. Required: RST cycle with regWrite=1, srcWrite=2, srcData=2. Then FETCH: irWrite=1 and pcWrite=1 only on its 2nd cycle.
2. opcode=0x00, funct=0x20, overflow=0. Required: R_EXEC has aluControl=001, aluOutControl=1. R_WB (5th cycle of the instruction) has regWrite=1, srcWrite=1, srcData=0. Back to FETCH.
3. Same instruction with overflow=1 during R_EXEC. Required: no regWrite. Next cycle epcControl=1, excpControl=1, iord=2, aluControl=010. Then pcWrite=1, pcSource=3. Then FETCH.
4. beq (0x04) with zero=1 -> pcWrite=1, pcSource=1. bne (0x05) with zero=1 -> pcWrite=0. j (0x02) -> pcWrite=1, pcSource=2.
5. MEM_WAIT=3, lw (0x23). Required: FETCH lasts 4 cycles; LW_MEM holds iord=1 for 3 cycles; LW_WB has srcData=1. sw (0x2B): memWrite=1 for exactly 1 cycle with iord=1.
6. opcode=0x3F -> EXC_OPC with excpControl=0. Separately, reset asserted mid-cycle during SW_MEM -> memWrite falls immediately without waiting for a clock edge; after release, state is RST.

Source files
------------

// File: rtl/mips_control_unit.sv
// ----------------------------------------------------------------------------
// mips_control_unit
//
// Multicycle Moore control FSM for the MIPS datapath. Decodes the current
// state (and the memory wait counter) into every mux select and write enable
// the datapath needs. Covers fetch/decode, R-type add/sub/and, addi, lw, sw,
// beq, bne, j, the $29 stack-pointer init after reset, and exception entry for
// invalid opcodes and arithmetic overflow.
//
// Parameters:
//   MEM_WAIT      cycles from address presentation to valid read data (>=1)
//
// Ports:
//   clk           system clock
//   reset         asynchronous, active-high reset
//   opcode        instruction bits [31:26]
//   funct         instruction bits [5:0]
//   zero          ALU result == 0
//   overflow      ALU signed overflow
//   pcWrite       PC load enable
//   iord          memory address select (0=PC, 1=ALUOut, 2=vector, 3=ALU)
//   excpControl   vector select (0=opcode, 1=overflow, 2=reserved)
//   memWrite      memory write strobe
//   irWrite       instruction register load
//   abWrite       A/B register load
//   srcWrite      destination select (0=rt, 1=rd, 2=$29, 3=$30, 4=$31)
//   srcData       write data select (0=ALUOut, 1=load data, 2=constant 227)
//   regWrite      register file write enable
//   aluSrcA       ALU A operand (0=PC, 1=A)
//   aluSrcB       ALU B operand (0=B, 1=4, 2=imm, 3=imm<<2)
//   aluControl    ALU op (001=add, 010=sub, 011=and, 000=idle)
//   aluOutControl ALUOut load enable
//   pcSource      PC source (0=ALU, 1=ALUOut, 2=jump, 3=MDR, 4=EPC)
//   epcControl    EPC load enable
// ----------------------------------------------------------------------------
module mips_control_unit #(
    parameter int unsigned MEM_WAIT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       overflow,
    output logic       pcWrite,
    output logic [1:0] iord,
    output logic [1:0] excpControl,
    output logic       memWrite,
    output logic       irWrite,
    output logic       abWrite,
    output logic [2:0] srcWrite,
    output logic [3:0] srcData,
    output logic       regWrite,
    output logic [1:0] aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [2:0] aluControl,
    output logic       aluOutControl,
    output logic [2:0] pcSource,
    output logic       epcControl
);

    localparam logic [5:0] OpRType = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpBne   = 6'h05;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;

    localparam logic [5:0] FnAdd = 6'h20;
    localparam logic [5:0] FnSub = 6'h22;
    localparam logic [5:0] FnAnd = 6'h24;

    localparam logic [2:0] AluIdle = 3'b000;
    localparam logic [2:0] AluAdd  = 3'b001;
    localparam logic [2:0] AluSub  = 3'b010;
    localparam logic [2:0] AluAnd  = 3'b011;

    // Counter must hold 0..MEM_WAIT (FETCH uses the full range).
    localparam int unsigned CntW = (MEM_WAIT > 1) ? $clog2(MEM_WAIT + 1) : 1;
    localparam logic [CntW-1:0] CntMax   = CntW'(MEM_WAIT);
    localparam logic [CntW-1:0] CntLast1 = CntW'(MEM_WAIT - 1);

    typedef enum logic [3:0] {
        StRst,
        StFetch,
        StDecode,
        StRExec,
        StRWb,
        StIExec,
        StIWb,
        StAddr,
        StLwMem,
        StLwWb,
        StSwMem,
        StBranch,
        StJump,
        StExcOpc,
        StExcOvf,
        StExcLoad
    } stateT;

    stateT           stateQ, stateD;
    logic [CntW-1:0] waitCntQ, waitCntD;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateQ   <= StRst;
            waitCntQ <= '0;
        end else begin
            stateQ   <= stateD;
            waitCntQ <= waitCntD;
        end
    end

    // Counter restarts on every state change and saturates at MEM_WAIT.
    always_comb begin
        if (stateD != stateQ) begin
            waitCntD = '0;
        end else if (waitCntQ == CntMax) begin
            waitCntD = CntMax;
        end else begin
            waitCntD = waitCntQ + CntW'(1);
        end
    end

    always_comb begin
        stateD        = stateQ;
        pcWrite       = 1'b0;
        iord          = 2'd0;
        excpControl   = 2'd0;
        memWrite      = 1'b0;
        irWrite       = 1'b0;
        abWrite       = 1'b0;
        srcWrite      = 3'd0;
        srcData       = 4'd0;
        regWrite      = 1'b0;
        aluSrcA       = 2'd0;
        aluSrcB       = 2'd0;
        aluControl    = AluIdle;
        aluOutControl = 1'b0;
        pcSource      = 3'd0;
        epcControl    = 1'b0;

        // Outputs are held at zero for as long as reset is asserted, so a
        // write strobe drops without waiting for a clock edge.
        if (!reset) begin
            unique case (stateQ)
                StRst: begin
                    regWrite = 1'b1;
                    srcWrite = 3'd2;
                    srcData  = 4'd2;
                    stateD   = StFetch;
                end

                StFetch: begin
                    iord       = 2'd0;
                    aluSrcA    = 2'd0;
                    aluSrcB    = 2'd1;
                    aluControl = AluAdd;
                    if (waitCntQ == CntMax) begin
                        irWrite  = 1'b1;
                        pcWrite  = 1'b1;
                        pcSource = 3'd0;
                        stateD   = StDecode;
                    end
                end

                StDecode: begin
                    abWrite       = 1'b1;
                    aluSrcA       = 2'd0;
                    aluSrcB       = 2'd3;
                    aluControl    = AluAdd;
                    aluOutControl = 1'b1;
                    case (opcode)
                        OpRType: begin
                            if (funct == FnAdd || funct == FnSub || funct == FnAnd) begin
                                stateD = StRExec;
                            end else begin
                                stateD = StExcOpc;
                            end
                        end
                        OpAddi:      stateD = StIExec;
                        OpLw, OpSw:  stateD = StAddr;
                        OpBeq, OpBne: stateD = StBranch;
                        OpJ:         stateD = StJump;
                        default:     stateD = StExcOpc;
                    endcase
                end

                StRExec: begin
                    aluSrcA       = 2'd1;
                    aluSrcB       = 2'd0;
                    aluOutControl = 1'b1;
                    case (funct)
                        FnAdd:   aluControl = AluAdd;
                        FnSub:   aluControl = AluSub;
                        FnAnd:   aluControl = AluAnd;
                        default: aluControl = AluIdle;
                    endcase
                    // A logical AND cannot overflow; the flag is stale there.
                    if (overflow && funct != FnAnd) begin
                        stateD = StExcOvf;
                    end else begin
                        stateD = StRWb;
                    end
                end

                StRWb: begin
                    regWrite = 1'b1;
                    srcWrite = 3'd1;
                    srcData  = 4'd0;
                    stateD   = StFetch;
                end

                StIExec: begin
                    aluSrcA       = 2'd1;
                    aluSrcB       = 2'd2;
                    aluControl    = AluAdd;
                    aluOutControl = 1'b1;
                    stateD        = overflow ? StExcOvf : StIWb;
                end

                StIWb: begin
                    regWrite = 1'b1;
                    srcWrite = 3'd0;
                    srcData  = 4'd0;
                    stateD   = StFetch;
                end

                StAddr: begin
                    aluSrcA       = 2'd1;
                    aluSrcB       = 2'd2;
                    aluControl    = AluAdd;
                    aluOutControl = 1'b1;
                    stateD        = (opcode == OpLw) ? StLwMem : StSwMem;
                end

                StLwMem: begin
                    iord = 2'd1;
                    if (waitCntQ == CntLast1) begin
                        stateD = StLwWb;
                    end
                end

                StLwWb: begin
                    regWrite = 1'b1;
                    srcWrite = 3'd0;
                    srcData  = 4'd1;
                    stateD   = StFetch;
                end

                StSwMem: begin
                    iord     = 2'd1;
                    memWrite = 1'b1;
                    stateD   = StFetch;
                end

                StBranch: begin
                    aluSrcA    = 2'd1;
                    aluSrcB    = 2'd0;
                    aluControl = AluSub;
                    // opcode[0] distinguishes bne (1) from beq (0).
                    if (zero ^ opcode[0]) begin
                        pcWrite  = 1'b1;
                        pcSource = 3'd1;
                    end
                    stateD = StFetch;
                end

                StJump: begin
                    pcWrite  = 1'b1;
                    pcSource = 3'd2;
                    stateD   = StFetch;
                end

                StExcOpc, StExcOvf: begin
                    iord        = 2'd2;
                    excpControl = (stateQ == StExcOvf) ? 2'd1 : 2'd0;
                    // PC already points past the faulting instruction.
                    if (waitCntQ == '0) begin
                        aluSrcA    = 2'd0;
                        aluSrcB    = 2'd1;
                        aluControl = AluSub;
                        epcControl = 1'b1;
                    end
                    if (waitCntQ == CntLast1) begin
                        stateD = StExcLoad;
                    end
                end

                StExcLoad: begin
                    pcWrite  = 1'b1;
                    pcSource = 3'd3;
                    stateD   = StFetch;
                end

                default: stateD = StRst;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_control_unit.sv
// ----------------------------------------------------------------------------
// tb_mips_control_unit
//
// Self-checking bench for mips_control_unit. Two instances (MEM_WAIT=1 and
// MEM_WAIT=3) are exercised one at a time while the other is held in reset.
// For each instruction a reference model expands the instruction into the
// list of per-cycle control words it must produce; every cycle is compared.
// ----------------------------------------------------------------------------
module tb_mips_control_unit;

    typedef struct packed {
        logic       pcWrite;
        logic [1:0] iord;
        logic [1:0] excpControl;
        logic       memWrite;
        logic       irWrite;
        logic       abWrite;
        logic [2:0] srcWrite;
        logic [3:0] srcData;
        logic       regWrite;
        logic [1:0] aluSrcA;
        logic [1:0] aluSrcB;
        logic [2:0] aluControl;
        logic       aluOutControl;
        logic [2:0] pcSource;
        logic       epcControl;
    } ctlT;

    logic       clk = 1'b0;
    logic       reset1, reset3;
    logic [5:0] opcode, funct;
    logic       zero, overflow;

    logic       pcWrite1, memWrite1, irWrite1, abWrite1, regWrite1, aluOutControl1, epcControl1;
    logic [1:0] iord1, excpControl1, aluSrcA1, aluSrcB1;
    logic [2:0] srcWrite1, aluControl1, pcSource1;
    logic [3:0] srcData1;
    logic       pcWrite3, memWrite3, irWrite3, abWrite3, regWrite3, aluOutControl3, epcControl3;
    logic [1:0] iord3, excpControl3, aluSrcA3, aluSrcB3;
    logic [2:0] srcWrite3, aluControl3, pcSource3;
    logic [3:0] srcData3;

    ctlT obs1, obs3;
    int  curMw;
    int  checks = 0;
    int  errors = 0;
    ctlT   expQ[$];
    string tagQ[$];

    always #5 clk = ~clk;

    mips_control_unit #(.MEM_WAIT(1)) dut1 (
        .clk(clk), .reset(reset1), .opcode(opcode), .funct(funct), .zero(zero),
        .overflow(overflow), .pcWrite(pcWrite1), .iord(iord1), .excpControl(excpControl1),
        .memWrite(memWrite1), .irWrite(irWrite1), .abWrite(abWrite1), .srcWrite(srcWrite1),
        .srcData(srcData1), .regWrite(regWrite1), .aluSrcA(aluSrcA1), .aluSrcB(aluSrcB1),
        .aluControl(aluControl1), .aluOutControl(aluOutControl1), .pcSource(pcSource1),
        .epcControl(epcControl1)
    );

    mips_control_unit #(.MEM_WAIT(3)) dut3 (
        .clk(clk), .reset(reset3), .opcode(opcode), .funct(funct), .zero(zero),
        .overflow(overflow), .pcWrite(pcWrite3), .iord(iord3), .excpControl(excpControl3),
        .memWrite(memWrite3), .irWrite(irWrite3), .abWrite(abWrite3), .srcWrite(srcWrite3),
        .srcData(srcData3), .regWrite(regWrite3), .aluSrcA(aluSrcA3), .aluSrcB(aluSrcB3),
        .aluControl(aluControl3), .aluOutControl(aluOutControl3), .pcSource(pcSource3),
        .epcControl(epcControl3)
    );

    assign obs1 = {pcWrite1, iord1, excpControl1, memWrite1, irWrite1, abWrite1, srcWrite1,
                   srcData1, regWrite1, aluSrcA1, aluSrcB1, aluControl1, aluOutControl1,
                   pcSource1, epcControl1};
    assign obs3 = {pcWrite3, iord3, excpControl3, memWrite3, irWrite3, abWrite3, srcWrite3,
                   srcData3, regWrite3, aluSrcA3, aluSrcB3, aluControl3, aluOutControl3,
                   pcSource3, epcControl3};

    function automatic ctlT obsNow();
        return (curMw == 1) ? obs1 : obs3;
    endfunction

    task automatic checkEq(input string tag, input logic [27:0] got, input logic [27:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s mw=%0d got=%h expected=%h", tag, curMw, got, exp);
        end
    endtask

    task automatic push(input string tag, input ctlT c);
        expQ.push_back(c);
        tagQ.push_back(tag);
    endtask

    function automatic ctlT rstRec();
        ctlT c = '0;
        c.regWrite = 1'b1;
        c.srcWrite = 3'd2;
        c.srcData  = 4'd2;
        return c;
    endfunction

    // Exception entry: MEM_WAIT cycles reading the vector, EPC captured on
    // the first, then one cycle loading the PC from the fetched vector byte.
    task automatic modelExc(input int mw, input int kind);
        ctlT c;
        for (int i = 0; i < mw; i++) begin
            c = '0;
            c.iord        = 2'd2;
            c.excpControl = 2'(kind);
            if (i == 0) begin
                c.aluSrcB    = 2'd1;
                c.aluControl = 3'b010;
                c.epcControl = 1'b1;
            end
            push("exc", c);
        end
        c = '0;
        c.pcWrite  = 1'b1;
        c.pcSource = 3'd3;
        push("excLoad", c);
    endtask

    task automatic modelInstr(input int mw, input logic [5:0] op, input logic [5:0] fn,
                              input logic z, input logic ov);
        ctlT c;
        for (int i = 0; i <= mw; i++) begin
            c = '0;
            c.aluSrcB    = 2'd1;
            c.aluControl = 3'b001;
            if (i == mw) begin
                c.irWrite = 1'b1;
                c.pcWrite = 1'b1;
            end
            push("fetch", c);
        end
        c = '0;
        c.abWrite = 1'b1;
        c.aluSrcB = 2'd3;
        c.aluControl = 3'b001;
        c.aluOutControl = 1'b1;
        push("decode", c);

        if (op == 6'h00 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24)) begin
            c = '0;
            c.aluSrcA = 2'd1;
            c.aluOutControl = 1'b1;
            c.aluControl = (fn == 6'h20) ? 3'b001 : (fn == 6'h22) ? 3'b010 : 3'b011;
            push("rExec", c);
            if (ov && fn != 6'h24) modelExc(mw, 1);
            else begin
                c = '0;
                c.regWrite = 1'b1;
                c.srcWrite = 3'd1;
                push("rWb", c);
            end
        end else if (op == 6'h08) begin
            c = '0;
            c.aluSrcA = 2'd1;
            c.aluSrcB = 2'd2;
            c.aluControl = 3'b001;
            c.aluOutControl = 1'b1;
            push("iExec", c);
            if (ov) modelExc(mw, 1);
            else begin
                c = '0;
                c.regWrite = 1'b1;
                push("iWb", c);
            end
        end else if (op == 6'h23 || op == 6'h2B) begin
            c = '0;
            c.aluSrcA = 2'd1;
            c.aluSrcB = 2'd2;
            c.aluControl = 3'b001;
            c.aluOutControl = 1'b1;
            push("addr", c);
            if (op == 6'h23) begin
                for (int i = 0; i < mw; i++) begin
                    c = '0;
                    c.iord = 2'd1;
                    push("lwMem", c);
                end
                c = '0;
                c.regWrite = 1'b1;
                c.srcData = 4'd1;
                push("lwWb", c);
            end else begin
                c = '0;
                c.iord = 2'd1;
                c.memWrite = 1'b1;
                push("swMem", c);
            end
        end else if (op == 6'h04 || op == 6'h05) begin
            c = '0;
            c.aluSrcA = 2'd1;
            c.aluControl = 3'b010;
            // beq taken on zero, bne taken on non-zero
            if ((op == 6'h04 && z) || (op == 6'h05 && !z)) begin
                c.pcWrite = 1'b1;
                c.pcSource = 3'd1;
            end
            push("branch", c);
        end else if (op == 6'h02) begin
            c = '0;
            c.pcWrite = 1'b1;
            c.pcSource = 3'd2;
            push("jump", c);
        end else begin
            modelExc(mw, 0);
        end
    endtask

    // Drive one instruction and compare every cycle except the last `skip`.
    task automatic runInstr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                            input logic ov, input int skip);
        opcode   = op;
        funct    = fn;
        zero     = z;
        overflow = ov;
        expQ.delete();
        tagQ.delete();
        modelInstr(curMw, op, fn, z, ov);
        for (int i = 0; i < expQ.size() - skip; i++) begin
            @(negedge clk);
            checkEq(tagQ[i], obsNow(), expQ[i]);
        end
    endtask

    task automatic runRandom(input int n);
        logic [5:0] op, fn;
        for (int k = 0; k < n; k++) begin
            fn = 6'($urandom);
            case ($urandom_range(0, 8))
                0, 8: begin
                    op = 6'h00;
                    case ($urandom_range(0, 3))
                        0: fn = 6'h20;
                        1: fn = 6'h22;
                        2: fn = 6'h24;
                        default: ;
                    endcase
                end
                1: op = 6'h08;
                2: op = 6'h23;
                3: op = 6'h2B;
                4: op = 6'h04;
                5: op = 6'h05;
                6: op = 6'h02;
                default: op = 6'($urandom);
            endcase
            runInstr(op, fn, 1'($urandom), ($urandom_range(0, 3) == 0), 0);
        end
    endtask

    initial begin
        ctlT c;
        reset1 = 1'b1;
        reset3 = 1'b1;
        opcode = '0;
        funct = '0;
        zero = 1'b0;
        overflow = 1'b0;
        curMw = 1;

        repeat (3) @(negedge clk);
        checkEq("resetHeld", obsNow(), '0);
        reset1 = 1'b0;
        #1 checkEq("rst", obsNow(), rstRec());

        runInstr(6'h00, 6'h20, 1'b0, 1'b0, 0);  // add
        runInstr(6'h00, 6'h20, 1'b0, 1'b1, 0);  // add overflow
        runInstr(6'h00, 6'h24, 1'b0, 1'b1, 0);  // and ignores overflow
        runInstr(6'h04, 6'h00, 1'b1, 1'b0, 0);  // beq taken
        runInstr(6'h05, 6'h00, 1'b1, 1'b0, 0);  // bne not taken
        runInstr(6'h05, 6'h00, 1'b0, 1'b0, 0);  // bne taken
        runInstr(6'h02, 6'h00, 1'b0, 1'b0, 0);  // j
        runInstr(6'h08, 6'h00, 1'b0, 1'b1, 0);  // addi overflow
        runInstr(6'h23, 6'h00, 1'b0, 1'b0, 0);  // lw
        runInstr(6'h2B, 6'h00, 1'b0, 1'b0, 0);  // sw
        runInstr(6'h3F, 6'h00, 1'b0, 1'b0, 0);  // invalid opcode
        runInstr(6'h00, 6'h2A, 1'b0, 1'b0, 0);  // invalid funct
        runRandom(40);

        // Switch to the MEM_WAIT=3 instance.
        reset1 = 1'b1;
        curMw = 3;
        @(negedge clk);
        checkEq("resetHeld3", obsNow(), '0);
        reset3 = 1'b0;
        #1 checkEq("rst3", obsNow(), rstRec());

        runInstr(6'h23, 6'h00, 1'b0, 1'b0, 0);
        runInstr(6'h2B, 6'h00, 1'b0, 1'b0, 0);
        runInstr(6'h00, 6'h22, 1'b0, 1'b1, 0);
        runInstr(6'h3F, 6'h00, 1'b0, 1'b0, 0);
        runRandom(25);

        // Reset arriving mid SW_MEM must drop memWrite before any clock edge.
        runInstr(6'h2B, 6'h00, 1'b0, 1'b0, 1);
        @(negedge clk);
        c = '0;
        c.iord = 2'd1;
        c.memWrite = 1'b1;
        checkEq("swMemBeforeReset", obsNow(), c);
        #2 reset3 = 1'b1;
        #1 checkEq("swMemWriteDrop", 28'(obsNow().memWrite), 28'd0);
        checkEq("swResetAllZero", obsNow(), '0);
        @(negedge clk);
        reset3 = 1'b0;
        #1 checkEq("rstAfterSw", obsNow(), rstRec());
        runInstr(6'h02, 6'h00, 1'b0, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
